// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the fetch pointer, issues one 16-bit instruction
// read at a time and queues returned words for the decoder.
// Jump/branch redirects flush the queue and squash any in-flight response;
// halt stops new requests while letting the outstanding one complete.
// Optional feature macro: IFETCH_BYPASS_EN -- when defined, a word acked
// while the queue is empty and the decoder is ready is handed over in the
// same cycle instead of being queued (zero-latency fetch).
module instruction_fetch #(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        d,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        halt,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK    = 2'd1,
        WAIT_SQUASH = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [15:0]    fetch_pc_reg;
    logic [15:0]    fetch_pc_next;
    logic [15:0]    mem_addr_reg;
    logic [15:0]    mem_addr_next;

    logic [PW-1:0]  rd_ptr_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_after;

    // each slot holds {pc, word}
    logic [DEPTH-1:0][31:0] slot_q;

    logic           q_push;
    logic           q_pop;
    logic           q_flush;
    logic           queue_empty;
    logic           bypass;
    logic [15:0]    pc_plus2;
    logic [15:0]    redirect_even;
    logic [31:0]    head_entry;

    assign queue_empty   = (count_reg == '0);
    assign pc_plus2      = fetch_pc_reg + 16'd2;
    assign redirect_even = {redirect_addr[15:1], 1'b0};
    assign head_entry    = slot_q[rd_ptr_reg];

    // A request is on the bus whenever one is outstanding, squashed or not.
    assign mem_req  = (state_reg != IDLE);
    assign mem_addr = mem_addr_reg;

`ifdef IFETCH_BYPASS_EN
    // Word goes straight to the decoder when nothing older is waiting.
    assign bypass      = queue_empty && (state_reg == WAIT_ACK) && !redirect
                         && mem_ack && instr_ready;
    assign instr_valid = !queue_empty || bypass;
    assign instr_out   = bypass ? mem_rdata    : head_entry[15:0];
    assign instr_pc    = bypass ? fetch_pc_reg : head_entry[31:16];
`else
    assign bypass      = 1'b0;
    assign instr_valid = !queue_empty;
    assign instr_out   = head_entry[15:0];
    assign instr_pc    = head_entry[31:16];
`endif

    // Pop only real queue entries; a bypassed word never occupies a slot.
    assign q_pop = !queue_empty && instr_ready;

    // Next-state, fetch pointer and queue control.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        mem_addr_next = mem_addr_reg;
        q_push        = 1'b0;
        q_flush       = 1'b0;
        count_after   = count_reg;
        case (state_reg)
            IDLE: begin
                if (redirect) begin
                    q_flush       = 1'b1;
                    fetch_pc_next = redirect_even;
                end else if (!halt && (count_reg < DEPTH_C)) begin
                    state_next    = WAIT_ACK;
                    mem_addr_next = fetch_pc_reg;
                end
            end
            WAIT_ACK: begin
                if (redirect) begin
                    // Acked word (if any) belongs to the old stream: drop it.
                    q_flush       = 1'b1;
                    fetch_pc_next = redirect_even;
                    state_next    = mem_ack ? IDLE : WAIT_SQUASH;
                end else if (mem_ack) begin
                    q_push        = !bypass;
                    fetch_pc_next = pc_plus2;
                    count_after   = count_reg + CW'(q_push) - CW'(q_pop);
                    // The next request will itself occupy a slot once issued.
                    if (!halt && (count_after < DEPTH_C)) begin
                        state_next    = WAIT_ACK;
                        mem_addr_next = pc_plus2;
                    end else begin
                        state_next    = IDLE;
                    end
                end
            end
            WAIT_SQUASH: begin
                if (redirect) begin
                    q_flush       = 1'b1;
                    fetch_pc_next = redirect_even;
                end
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state, fetch pointer and bus address registers.
    always_ff @(posedge d) begin
        if (reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= {RESET_ADDR[15:1], 1'b0};
            mem_addr_reg <= RESET_ADDR;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            mem_addr_reg <= mem_addr_next;
        end
    end

    // Queue pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge d) begin
        if (reset || q_flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (q_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (q_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(q_push) - CW'(q_pop);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [31:0] slot_reg;

            // Capture the returned word and its address into this slot.
            always_ff @(posedge d) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (q_push && (wr_ptr_reg == PW'(gi))) begin
                    slot_reg <= {fetch_pc_reg, mem_rdata};
                end
            end

            assign slot_q[gi] = slot_reg;
        end
    endgenerate

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a scoreboard queue receives
// {address, word} for every accepted ack and is compared against each
// word the decoder consumes; directed checks cover addressing, queue
// back-pressure, squash, wrap-around, halt, latency and reset.
module tb_instruction_fetch;

    logic        d;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;

`ifdef IFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    instruction_fetch #(.DEPTH(4), .RESET_ADDR(16'h0000)) dut (
        .d             (d),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc)
    );

    initial d = 1'b0;
    always #5 d = ~d;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];
    bit          squash_pending = 0;
    int          ack_cnt = 0;
    logic        last_acked = 1'b0;
    logic [15:0] last_ack_addr = 16'h0;
    bit          use_ovr = 0;
    logic [15:0] ovr = 16'h0;
    logic        same_valid = 1'b0;
    logic [15:0] same_out = 16'h0;
    logic [15:0] exp_addr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    // One clock cycle: drive inputs at negedge, model memory ack, score
    // deliveries, then return 1 time unit after the next posedge.
    task automatic tick(input bit ack_if_req, input bit rdir, input logic [15:0] raddr);
        logic        acked;
        logic [31:0] exp;
        @(negedge d);
        redirect      = rdir;
        redirect_addr = raddr;
        acked         = ack_if_req && mem_req;
        mem_ack       = acked;
        mem_rdata     = use_ovr ? ovr : (mem_addr ^ 16'h5A3C);
        last_acked    = acked;
        if (acked) begin
            ack_cnt++;
            last_ack_addr = mem_addr;
            if (!rdir && !squash_pending) sb.push_back({mem_addr, mem_rdata});
        end
        #1;
        same_valid = instr_valid;
        same_out   = instr_out;
        if (instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                exp = sb.pop_front();
                check_eq("deliver", {instr_pc, instr_out}, exp);
            end
        end
        if (mem_req) begin
            if (acked) squash_pending = 0;
            else if (rdir) squash_pending = 1;
        end
        if (rdir) sb.delete();
        @(posedge d);
        #1;
    endtask

    task automatic do_reset(input bit ack_during);
        @(negedge d);
        reset    = 1'b1;
        redirect = 1'b0;
        halt     = 1'b0;
        mem_ack  = ack_during;
        use_ovr  = 0;
        repeat (2) @(posedge d);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b0;
        sb.delete();
        squash_pending = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_addr = 16'h0; halt = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0; instr_ready = 1'b0;

        // Reset state
        do_reset(0);
        check_eq("rst_req",   {31'd0, mem_req}, 32'd0);
        check_eq("rst_addr",  {16'd0, mem_addr}, 32'h0000);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_out",   {16'd0, instr_out}, 32'd0);
        check_eq("rst_pc",    {16'd0, instr_pc}, 32'd0);

        // Sequential fetch with ack every cycle
        instr_ready = 1'b1;
        tick(1, 0, 16'h0);
        exp_addr = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 16'h0);
            check_eq("seq_acked", {31'd0, last_acked}, 32'd1);
            check_eq("seq_addr", {16'd0, last_ack_addr}, {16'd0, exp_addr});
            check_eq("seq_next", {16'd0, mem_addr}, {16'd0, exp_addr + 16'd2});
            if (!BYP) check_eq("seq_lat_pc", {15'd0, instr_valid, instr_pc}, {15'd0, 1'b1, exp_addr});
            exp_addr = exp_addr + 16'd2;
        end

        // Back-pressure: queue of 4 fills, then one pop frees one request
        do_reset(0);
        instr_ready = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 12; i++) tick(1, 0, 16'h0);
        check_eq("full_acks", ack_cnt, 32'd4);
        check_eq("full_req", {31'd0, mem_req}, 32'd0);
        check_eq("full_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        tick(0, 0, 16'h0);
        instr_ready = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) tick(1, 0, 16'h0);
        check_eq("refill_acks", ack_cnt, 32'd1);
        check_eq("refill_addr", {16'd0, last_ack_addr}, 32'h0008);
        check_eq("refill_req", {31'd0, mem_req}, 32'd0);
        tick(0, 1, 16'h0300);
        check_eq("flush_valid", {31'd0, instr_valid}, 32'd0);

        // Squash: request at 0010 stalled, redirect to 0100, ack DEAD
        do_reset(0);
        instr_ready = 1'b1;
        tick(0, 1, 16'h0010);
        check_eq("sq_idle_req", {31'd0, mem_req}, 32'd0);
        tick(0, 0, 16'h0);
        check_eq("sq_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0010});
        tick(0, 0, 16'h0);
        check_eq("sq_hold", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0010});
        tick(0, 1, 16'h0100);
        check_eq("sq_wait", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0010});
        use_ovr = 1; ovr = 16'hDEAD;
        tick(1, 0, 16'h0);
        check_eq("sq_same_valid", {31'd0, same_valid}, 32'd0);
        check_eq("sq_drop", {15'd0, mem_req, instr_valid}, 32'd0);
        use_ovr = 0;
        tick(0, 0, 16'h0);
        check_eq("sq_new_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0100});
        check_eq("sq_no_dead", {31'd0, instr_valid}, 32'd0);

        // Wrap-around and odd redirect address
        do_reset(0);
        instr_ready = 1'b0;
        tick(0, 1, 16'hFFFE);
        tick(0, 0, 16'h0);
        check_eq("wrap_addr", {16'd0, mem_addr}, 32'h0000FFFE);
        tick(1, 0, 16'h0);
        check_eq("wrap_next", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});
        check_eq("wrap_pc", {15'd0, instr_valid, instr_pc}, {15'd0, 1'b1, 16'hFFFE});
        tick(1, 1, 16'h0103);
        check_eq("rd_ack_drop", {15'd0, mem_req, instr_valid}, 32'd0);
        tick(0, 0, 16'h0);
        check_eq("odd_redirect", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0102});

        // Halt while a request is outstanding
        do_reset(0);
        instr_ready = 1'b1;
        tick(0, 0, 16'h0);
        check_eq("halt_pre", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});
        halt = 1'b1;
        tick(1, 0, 16'h0);
        check_eq("halt_acked", {31'd0, last_acked}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 16'h0);
            check_eq("halt_noreq", {31'd0, mem_req}, 32'd0);
        end
        check_eq("halt_drained", sb.size(), 32'd0);
        halt = 1'b0;
        tick(1, 0, 16'h0);
        check_eq("halt_resume", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0002});

        // Latency of first word after reset
        do_reset(0);
        instr_ready = 1'b1;
        tick(0, 0, 16'h0);
        use_ovr = 1; ovr = 16'h1234;
        tick(1, 0, 16'h0);
        check_eq("lat_same_valid", {31'd0, same_valid}, {31'd0, BYP});
        if (BYP) begin
            check_eq("lat_same_out", {16'd0, same_out}, 32'h1234);
            check_eq("lat_not_queued", {31'd0, instr_valid}, 32'd0);
        end else begin
            check_eq("lat_next", {15'd0, instr_valid, instr_out}, {15'd0, 1'b1, 16'h1234});
        end
        use_ovr = 0;

        // Reset mid-operation with a pending ack
        do_reset(1);
        check_eq("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("mid_rst_addr", {16'd0, mem_addr}, 32'h0000);
        check_eq("mid_rst_out", {instr_pc, instr_out}, 32'd0);
        tick(1, 0, 16'h0);
        check_eq("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        tick(1, 0, 16'h0);
        check_eq("mid_rst_first", {16'd0, last_ack_addr}, 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
